oisc_stack_unit: RTL and testbench
==================================

// Module: oisc_stack_unit
// PURPOSE
//  Parametrised hardware stack engine for the OISC memory block; replaces the ad-hoc stack logic.
//  Keeps the top-of-stack (TOS) in a register and spills the remaining entries to shared RAM,
//  which grows downward from BASE_ADDR. Single-cycle push; pop returns TOS combinationally.
//  Sits between the STACK/STACKR bus ports and the processor RAM port (1-cycle read latency).
// PARAMETERS
//  DWIDTH      8          stack entry width (bits)
//  DEPTH       256        max entries incl. TOS; power of two not required, >=2
//  RAM_AWIDTH  24         RAM address width
//  RAM_DWIDTH  16         RAM data width, >= DWIDTH
//  BASE_ADDR   24'hFFFFFF address of RAM slot 0; slot k lives at BASE_ADDR-k
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset, synchronous, active-high
//  push         in   1                    push request, qualified by ready
//  push_data    in   DWIDTH               data to push
//  pop          in   1                    pop request, qualified by ready
//  pop_data     out  DWIDTH               current TOS; 0 when empty
//  ready        out  1                    1 = push/pop accepted this cycle
//  flush        in   1                    discard all entries
//  count        out  $clog2(DEPTH+1)      entries held
//  empty/full   out  1                    count==0 / count==DEPTH
//  overflow     out  1                    sticky: push attempted while full
//  underflow    out  1                    sticky: pop attempted while empty
//  ram_addr     out  RAM_AWIDTH           RAM address, 0 when idle
//  ram_rd_en    out  1                    RAM read strobe
//  ram_wr_en    out  1                    RAM write strobe
//  ram_wr_data  out  RAM_DWIDTH           spilled entry, zero-extended
//  ram_rd_data  in   RAM_DWIDTH           RAM read data, valid 1 cycle after ram_rd_en
//  hwm          out  $clog2(DEPTH+1)      high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  Reset: count=0, TOS=0, state IDLE, overflow=underflow=0, hwm=0, all RAM strobes 0.
//  States: IDLE (ready=1), REFILL (ready=0, waits one cycle for ram_rd_data).
//  Priority: rst > flush > push/pop. flush: count<=0, TOS<=0, state<=IDLE; sticky flags kept.
//  push only, count==0: TOS<=push_data, count=1, no RAM access.
//  push only, 0<count<DEPTH: ram_wr_en=1, addr=BASE_ADDR-(count-1), data=old TOS;
//    TOS<=push_data, count++. Single cycle, stays IDLE.
//  push only, full: ignored, overflow<=1, nothing else changes.
//  pop only, count==1: pop_data=TOS, count=0, TOS<=0, no RAM access.
//  pop only, count>=2: pop_data=TOS this cycle; ram_rd_en=1, addr=BASE_ADDR-(count-2);
//    count--, ->REFILL; next cycle TOS<=ram_rd_data[DWIDTH-1:0], ->IDLE.
//  pop only, empty: pop_data=0, underflow<=1, no change.
//  push+pop same cycle, count>=1: pop_data=old TOS, TOS<=push_data, count unchanged, no RAM.
//  push+pop same cycle, empty: treated as push; underflow<=1.
//  push/pop while ready=0: ignored, no flag set (caller must hold off).
//  rst or flush in REFILL: arriving ram_rd_data discarded.
//  Address arithmetic modulo 2^RAM_AWIDTH; no other wrap (count saturates via full/empty).
// CONFIGURATION
//  OISC_STACK_WATERMARK_EN defined: hwm<=max(hwm,count_next) every cycle; cleared by rst only.
//  Not defined: hwm tied to 0, no register inferred.
// STRUCTURE
//  oisc8_pkg gains: typedef enum logic {STK_IDLE, STK_REFILL} e_stack_state;
//    localparam STACK_BASE_ADDR used as default BASE_ADDR at the mem_block instance.
//  Single module, FSM inline; no sub-module. mem_block instantiates it and muxes ram_* with
//    its pointer-based access (stack strobes take priority).
// TESTING
//  Push 8'h11,22,33 -> count=3, RAM writes 11@FFFFFF, 22@FFFFFE, pop_data=33.
//  Pop from count=3 -> pop_data=33, ram_rd_en addr FFFFFE, ready=0 one cycle, then TOS=22.
//  Push+pop at count=2 with 8'hAA -> pop_data=old TOS, TOS=AA, count=2, no RAM strobes.
//  DEPTH=4: 5 pushes -> full=1, overflow=1, count=4, 5th value not stored.
//  Pop when empty -> pop_data=0, underflow=1; flush at count=3 -> count=0, flags kept.
//  rst asserted during REFILL -> next cycle count=0, ready=1, TOS=0, no stale load.

Source files
------------

// File: rtl/oisc8_pkg.sv
// Shared types and constants for the OISC8 memory block.
// Holds the stack-engine state encoding and the default spill base address.
package oisc8_pkg;

   typedef enum logic {STK_IDLE, STK_REFILL} e_stack_state;

   localparam logic [23:0] STACK_BASE_ADDR = 24'hFFFFFF;

endpackage

// File: rtl/oisc_stack_unit.sv
// Hardware stack: TOS held in a register, deeper entries spilled downward into shared RAM.
// Optional high-water mark enabled by defining OISC_STACK_WATERMARK_EN.
module oisc_stack_unit
   import oisc8_pkg::*;
#(
   parameter int unsigned             DWIDTH     = 8,
   parameter int unsigned             DEPTH      = 256,
   parameter int unsigned             RAM_AWIDTH = 24,
   parameter int unsigned             RAM_DWIDTH = 16,
   parameter logic [RAM_AWIDTH-1:0]   BASE_ADDR  = RAM_AWIDTH'(STACK_BASE_ADDR)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DWIDTH-1:0]             push_data,
   input  logic                          pop,
   output logic [DWIDTH-1:0]             pop_data,
   output logic                          ready,
   input  logic                          flush,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          empty,
   output logic                          full,
   output logic                          overflow,
   output logic                          underflow,
   output logic [RAM_AWIDTH-1:0]         ram_addr,
   output logic                          ram_rd_en,
   output logic                          ram_wr_en,
   output logic [RAM_DWIDTH-1:0]         ram_wr_data,
   input  logic [RAM_DWIDTH-1:0]         ram_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]    hwm
);

   localparam int unsigned    CW      = $clog2(DEPTH+1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  ONE_C   = CW'(1);

   e_stack_state       state, state_next;
   logic [DWIDTH-1:0]  tos, tos_next;
   logic [CW-1:0]      count_next;
   logic               set_ovf, set_unf;
   logic               go, do_push, do_pop;
   logic               unused_rd_bits;

   // Upper RAM data bits beyond DWIDTH are intentionally dropped on refill.
   assign unused_rd_bits = ^{1'b0, ram_rd_data};

   assign ready    = (state == STK_IDLE);
   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign pop_data = empty ? '0 : tos;

   assign go      = ready && !rst && !flush;
   assign do_push = go && push;
   assign do_pop  = go && pop;

   always_comb begin
      state_next  = state;
      tos_next    = tos;
      count_next  = count;
      set_ovf     = 1'b0;
      set_unf     = 1'b0;
      ram_addr    = '0;
      ram_rd_en   = 1'b0;
      ram_wr_en   = 1'b0;
      ram_wr_data = '0;

      if (state == STK_REFILL) begin
         tos_next   = ram_rd_data[DWIDTH-1:0];
         state_next = STK_IDLE;
      end else if (do_push && do_pop) begin
         tos_next = push_data;
         if (empty) begin
            count_next = ONE_C;
            set_unf    = 1'b1;
         end
      end else if (do_push) begin
         if (empty) begin
            tos_next   = push_data;
            count_next = ONE_C;
         end else if (full) begin
            set_ovf = 1'b1;
         end else begin
            ram_wr_en   = 1'b1;
            ram_addr    = BASE_ADDR - RAM_AWIDTH'(count - ONE_C);
            ram_wr_data = RAM_DWIDTH'(tos);
            tos_next    = push_data;
            count_next  = count + ONE_C;
         end
      end else if (do_pop) begin
         if (empty) begin
            set_unf = 1'b1;
         end else if (count == ONE_C) begin
            tos_next   = '0;
            count_next = '0;
         end else begin
            ram_rd_en  = 1'b1;
            ram_addr   = BASE_ADDR - RAM_AWIDTH'(count - CW'(2));
            count_next = count - ONE_C;
            state_next = STK_REFILL;
         end
      end

      // Flush overrides everything, including a pending refill load.
      if (flush) begin
         state_next = STK_IDLE;
         tos_next   = '0;
         count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= STK_IDLE;
         tos       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state <= state_next;
         tos   <= tos_next;
         count <= count_next;
         if (set_ovf) overflow  <= 1'b1;
         if (set_unf) underflow <= 1'b1;
      end
   end

`ifdef OISC_STACK_WATERMARK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hwm <= '0;
      end else if (count_next > hwm) begin
         hwm <= count_next;
      end
   end
`else
   assign hwm = '0;
`endif

endmodule

// File: tb/tb_oisc_stack_unit.sv
// Directed bench for oisc_stack_unit (DEPTH=4) with a small behavioural RAM.
// Expected hwm values follow OISC_STACK_WATERMARK_EN when defined.
module tb_oisc_stack_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
   logic [7:0]  push_data = '0;
   logic [7:0]  pop_data;
   logic        ready, empty, full, overflow, underflow;
   logic [2:0]  count, hwm;
   logic [23:0] ram_addr;
   logic        ram_rd_en, ram_wr_en;
   logic [15:0] ram_wr_data;
   logic [15:0] ram_rd_data = 16'hBEEF;

   logic [15:0] mem [0:15];
   logic [23:0] slot;

   logic        s_wr, s_rd;
   logic [23:0] s_addr;
   logic [15:0] s_wdata;
   logic [7:0]  s_pop;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

`ifdef OISC_STACK_WATERMARK_EN
   localparam bit HWM_EN = 1'b1;
`else
   localparam bit HWM_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   oisc_stack_unit #(
      .DWIDTH(8), .DEPTH(4), .RAM_AWIDTH(24), .RAM_DWIDTH(16), .BASE_ADDR(24'hFFFFFF)
   ) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .ready(ready), .flush(flush), .count(count),
      .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
      .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .hwm(hwm)
   );

   // RAM with one-cycle read latency; BEEF appears whenever no read was issued.
   assign slot = 24'hFFFFFF - ram_addr;
   always @(posedge clk) begin
      if (ram_wr_en) mem[slot[3:0]] <= ram_wr_data;
      ram_rd_data <= ram_rd_en ? mem[slot[3:0]] : 16'hBEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input logic p, input logic [7:0] d, input logic q,
                       input logic f, input logic r);
      push = p; push_data = d; pop = q; flush = f; rst = r;
      #2;
      s_wr = ram_wr_en; s_rd = ram_rd_en; s_addr = ram_addr;
      s_wdata = ram_wr_data; s_pop = pop_data;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; rst = 1'b0; push_data = '0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      @(posedge clk); #1;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_pop_data", 32'(pop_data), 32'h0);
      check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
      check("rst_hwm", 32'(hwm), 32'd0);
      check("rst_strobes", {30'd0, ram_wr_en, ram_rd_en}, 32'd0);

      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      check("push1_no_ram", {30'd0, s_wr, s_rd}, 32'd0);
      check("push1_addr_idle", 32'(s_addr), 32'd0);
      check("push1_count", 32'(count), 32'd1);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      check("push2_wr", {7'd0, s_wr, s_addr}, {7'd0, 1'b1, 24'hFFFFFF});
      check("push2_wdata", 32'(s_wdata), 32'h0011);
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      check("push3_wr", {7'd0, s_wr, s_addr}, {7'd0, 1'b1, 24'hFFFFFE});
      check("push3_wdata", 32'(s_wdata), 32'h0022);
      check("push3_count", 32'(count), 32'd3);
      check("push3_tos", 32'(pop_data), 32'h33);
      check("push3_hwm", 32'(hwm), HWM_EN ? 32'd3 : 32'd0);

      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("pop_data", 32'(s_pop), 32'h33);
      check("pop_rd", {7'd0, s_rd, s_addr}, {7'd0, 1'b1, 24'hFFFFFE});
      check("pop_no_wr", 32'(s_wr), 32'd0);
      check("pop_ready0", 32'(ready), 32'd0);
      check("pop_count", 32'(count), 32'd2);
      // Push while refilling must be ignored without raising a flag.
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      check("refill_push_ignored", {30'd0, s_wr, s_rd}, 32'd0);
      check("refill_ready", 32'(ready), 32'd1);
      check("refill_tos", 32'(pop_data), 32'h22);
      check("refill_count", 32'(count), 32'd2);
      check("refill_flags", {30'd0, overflow, underflow}, 32'd0);

      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      check("swap_pop_data", 32'(s_pop), 32'h22);
      check("swap_no_ram", {30'd0, s_wr, s_rd}, 32'd0);
      check("swap_count", 32'(count), 32'd2);
      check("swap_tos", 32'(pop_data), 32'hAA);

      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      check("fill3_wr", {7'd0, s_wr, s_addr}, {7'd0, 1'b1, 24'hFFFFFE});
      check("fill3_wdata", 32'(s_wdata), 32'h00AA);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      check("fill4_wr", {7'd0, s_wr, s_addr}, {7'd0, 1'b1, 24'hFFFFFD});
      check("full_flag", 32'(full), 32'd1);
      check("full_ovf_clear", 32'(overflow), 32'd0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      check("ovf_no_wr", 32'(s_wr), 32'd0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd4);
      check("ovf_tos_kept", 32'(pop_data), 32'h55);
      check("ovf_hwm", 32'(hwm), HWM_EN ? 32'd4 : 32'd0);

      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_pop_data", 32'(pop_data), 32'h0);
      check("flush_ovf_kept", 32'(overflow), 32'd1);
      check("flush_hwm_kept", 32'(hwm), HWM_EN ? 32'd4 : 32'd0);

      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("unf_pop_data", 32'(s_pop), 32'h0);
      check("unf_no_rd", 32'(s_rd), 32'd0);
      check("unf_flag", 32'(underflow), 32'd1);
      check("unf_count", 32'(count), 32'd0);

      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      check("pre_rst_wdata", 32'(s_wdata), 32'h0001);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("pre_rst_rd", {7'd0, s_rd, s_addr}, {7'd0, 1'b1, 24'hFFFFFF});
      check("pre_rst_ready0", 32'(ready), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("rst_refill_count", 32'(count), 32'd0);
      check("rst_refill_ready", 32'(ready), 32'd1);
      check("rst_refill_tos", 32'(pop_data), 32'h0);
      check("rst_refill_flags", {30'd0, overflow, underflow}, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("rst_refill_no_stale", {24'd0, pop_data}, 32'h0);
      check("rst_refill_empty", 32'(empty), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
